// File: rtl/port_pic.sv
// port_pic: small 8-line programmable interrupt controller on an I/O port pair.
// BASE_PORT is the command/status port and BASE_PORT+1 is the data/mask port.
// Delivery uses a toggle handshake: a request is pending while intr != intl.
// Optional feature: define PIC_AUTO_EOI_EN to get auto-EOI behaviour, where an
// acknowledge never marks a line in service and EOI writes are inert.
module port_pic #(
  parameter logic [15:0] BASE_PORT = 16'h0020,
  parameter logic [7:0]  VEC_RESET = 8'h08
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] port,
  input  logic        port_clk,
  input  logic        port_w,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  input  logic [7:0]  irq_line,
  output logic [7:0]  irq,
  output logic        intr,
  input  logic        intl
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [7:0] line_s1, line_s2, line_s3;
  logic [7:0] line_rise;
  logic       port_clk_d;
  logic       access, hit_cmd, hit_data;
  logic [7:0] irr, isr, imr;
  logic [4:0] vec_hi;
  logic       rd_isr, vec_armed;
  logic [0:0] state;
  logic [2:0] cur_n;
  logic       ack;
  logic [7:0] ack_mask;
  logic [7:0] blocked, eligible;
  logic [2:0] sel_n;

  // Two-flop synchronizer plus one history stage for rising-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_s1 <= 8'h00;
      line_s2 <= 8'h00;
      line_s3 <= 8'h00;
    end else begin
      line_s1 <= irq_line;
      line_s2 <= line_s1;
      line_s3 <= line_s2;
    end
  end

  assign line_rise = line_s2 & ~line_s3;

  // Remember the previous strobe level so an access is decoded once per rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) port_clk_d <= 1'b0;
    else          port_clk_d <= port_clk;
  end

  assign access   = port_clk & ~port_clk_d;
  assign hit_cmd  = access && (port == BASE_PORT);
  assign hit_data = access && (port == BASE_PORT + 16'd1);

  assign ack      = (state == PEND) && (intl == intr);
  assign ack_mask = 8'd1 << cur_n;

  // Line n is blocked by any in-service line of equal or higher priority.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_blk
    assign blocked[gi] = |isr[gi:0];
  end

  assign eligible = irr & ~imr & ~blocked;

  // Lowest-index eligible line wins.
  always_comb begin
    sel_n = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) sel_n = 3'(i);
    end
  end

  // Request register: new edges set, acknowledge clears; a same-cycle set wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irr <= 8'h00;
    else          irr <= (irr & ~(ack ? ack_mask : 8'h00)) | line_rise;
  end

`ifdef PIC_AUTO_EOI_EN
  // In-service register never fills in auto-EOI mode, so EOI has nothing to clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) isr <= 8'h00;
    else          isr <= isr;
  end
`else
  logic       eoi_req;
  logic [7:0] isr_low;

  assign eoi_req = hit_cmd && port_w && (port_o == 8'h20);
  assign isr_low = isr & (~isr + 8'd1);

  // In-service register: EOI clears the old lowest bit before the acknowledge sets its bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) isr <= 8'h00;
    else          isr <= (isr & ~(eoi_req ? isr_low : 8'h00)) | (ack ? ack_mask : 8'h00);
  end
`endif

  // Configuration writes: read select, vector arming, vector base and mask.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imr       <= 8'hFF;
      vec_hi    <= VEC_RESET[7:3];
      rd_isr    <= 1'b0;
      vec_armed <= 1'b0;
    end else begin
      if (hit_cmd && port_w) begin
        if (port_o == 8'h0A)      rd_isr    <= 1'b0;
        else if (port_o == 8'h0B) rd_isr    <= 1'b1;
        else if (port_o != 8'h20 && port_o[4]) vec_armed <= 1'b1;
      end
      if (hit_data && port_w) begin
        if (vec_armed) begin
          vec_hi    <= port_o[7:3];
          vec_armed <= 1'b0;
        end else begin
          imr <= port_o;
        end
      end
    end
  end

  // Read data is captured on the decode cycle and held until the next read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) port_i <= 8'h00;
    else if (hit_cmd && !port_w)  port_i <= rd_isr ? isr : irr;
    else if (hit_data && !port_w) port_i <= imr;
  end

  // Delivery handshake: raise a request from IDLE, hold it in PEND until acknowledged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      intr  <= 1'b0;
      irq   <= 8'h00;
      cur_n <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if ((intr == intl) && (|eligible)) begin
            irq   <= {vec_hi, sel_n};
            cur_n <= sel_n;
            intr  <= ~intr;
            state <= PEND;
          end
        end
        default: begin
          if (ack) state <= IDLE;
        end
      endcase
    end
  end

endmodule
